// File: rtl/apb_uart_ctrl.sv
// apb_uart_ctrl: APB master that configures a UART, then polls its status and moves bytes between it and two byte streams
// Ports: CLK, RST (sync, active-high)
//        PADDR/PWDATA/PWRITE/PSEL/PENABLE out, PRDATA/PREADY/PSLVERR in: APB master side
//        tx_data/tx_valid in, tx_ready out: bytes to transmit
//        rx_data/rx_valid out, rx_ready in: received bytes
//        init_done: divisor and line control written; err_o: sticky PSLVERR or PREADY timeout
module apb_uart_ctrl #(
    parameter logic [31:0] DIV_ADDR   = 32'h0000_0000,
    parameter logic [31:0] LCR_ADDR   = 32'h0000_0004,
    parameter logic [31:0] STAT_ADDR  = 32'h0000_0008,
    parameter logic [31:0] TXD_ADDR   = 32'h0000_000C,
    parameter logic [31:0] RXD_ADDR   = 32'h0000_0010,
    parameter logic [31:0] DIV_VALUE  = 32'd54,
    parameter logic [31:0] LCR_VALUE  = 32'h0000_0003,
    parameter int          TX_RDY_BIT = 0,
    parameter int          RX_VLD_BIT = 1,
    parameter int          TIMEOUT    = 16
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        err_o
);
    typedef enum logic [2:0] {RESET_INIT, WR_DIV, WR_LCR, POLL, RD_RX, WR_TX} state_t;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} phase_t;
    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [15:0] cnt;
    logic [7:0]  tx_byte;
    logic        last_tx, init_step, done, tmo, stat_ok, rx_el, tx_el, pick_rx, pick_tx;
    logic        unused_prdata;
    assign unused_prdata = ^PRDATA;
    always_comb begin
        init_step = state == WR_DIV || state == WR_LCR;
        done      = phase == ACCESS && PREADY;
        // cnt holds the waits already seen, so this cycle is wait number cnt+1
        tmo       = phase == ACCESS && !PREADY && 32'(cnt) >= 32'(TIMEOUT - 1);
        stat_ok   = state == POLL && done && !PSLVERR;
        rx_el     = stat_ok && PRDATA[RX_VLD_BIT] && !rx_valid;
        tx_el     = stat_ok && PRDATA[TX_RDY_BIT] && tx_valid;
        // round robin: RX wins a tie unless it was served last
        pick_rx   = rx_el && (!tx_el || last_tx);
        pick_tx   = tx_el && !pick_rx;
        tx_ready  = pick_tx;
        state_n   = state;
        phase_n   = phase;
        if (state == RESET_INIT) begin
            state_n = WR_DIV;
            phase_n = SETUP;
        end else if (phase == IDLE) begin
            phase_n = SETUP;
        end else if (phase == SETUP) begin
            phase_n = ACCESS;
        end else if (done) begin
            phase_n = IDLE;
            state_n = state == WR_DIV ? WR_LCR : pick_rx ? RD_RX : pick_tx ? WR_TX : POLL;
        end else if (tmo) begin
            phase_n = IDLE;
            state_n = init_step ? state : POLL;
        end
        PSEL    = state != RESET_INIT && phase != IDLE;
        PENABLE = phase == ACCESS;
        PWRITE  = init_step || state == WR_TX;
        PADDR   = state == WR_DIV ? DIV_ADDR :
                  state == WR_LCR ? LCR_ADDR :
                  state == POLL   ? STAT_ADDR :
                  state == RD_RX  ? RXD_ADDR :
                  state == WR_TX  ? TXD_ADDR : 32'h0;
        PWDATA  = state == WR_DIV ? DIV_VALUE :
                  state == WR_LCR ? LCR_VALUE :
                  state == WR_TX  ? {24'h0, tx_byte} : 32'h0;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RESET_INIT;
            phase     <= IDLE;
            cnt       <= '0;
            tx_byte   <= '0;
            last_tx   <= 1'b1;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            init_done <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            cnt     <= phase == SETUP ? 16'h0 : phase == ACCESS && !PREADY && cnt != 16'hFFFF ? cnt + 16'd1 : cnt;
            if (pick_tx) tx_byte <= tx_data;
            if (pick_rx || pick_tx) last_tx <= pick_tx;
            if (state == RD_RX && done && !PSLVERR) begin
                rx_valid <= 1'b1;
                rx_data  <= PRDATA[7:0];
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (state == WR_LCR && done) init_done <= 1'b1;
            if ((done && PSLVERR) || tmo) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_uart_ctrl.sv
// tb_apb_uart_ctrl: directed scoreboard bench for apb_uart_ctrl with a simple APB slave model
module tb_apb_uart_ctrl;
    typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} txn_t;
    logic        CLK = 1'b0, RST = 1'b1;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [7:0]  tx_data = 8'h0, rx_data;
    logic        tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0, init_done, err_o;
    logic        stall = 1'b0, slverr_rx = 1'b0;
    logic [31:0] stat_val = 32'h0, rxd_val = 32'h0;
    txn_t        act_q[$], exp_q[$];
    int          rd = 0, total = 0, passed = 0, txr_cnt = 0;

    apb_uart_ctrl dut (
        .CLK(CLK), .RST(RST), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .init_done(init_done), .err_o(err_o)
    );

    always #5 CLK = ~CLK;

    assign PREADY  = !stall;
    assign PRDATA  = PADDR == 32'h8 ? stat_val : PADDR == 32'h10 ? rxd_val : 32'h0;
    assign PSLVERR = slverr_rx && PADDR == 32'h10;

    always @(negedge CLK) begin
        if (!RST && PSEL && PENABLE && PREADY) act_q.push_back({PWRITE, PADDR, PWRITE ? PWDATA : PRDATA});
        if (tx_ready) txr_cnt++;
    end

    task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_exp(logic w, logic [31:0] a, logic [31:0] d);
        exp_q.push_back({w, a, d});
    endtask

    task automatic check_txn(string tag, bit skip);
        txn_t t, e;
        bit   got = 0;
        e = exp_q.pop_front();
        for (int i = 0; i < 400 && !got; i++) begin
            while (rd < act_q.size() && !got) begin
                t = act_q[rd];
                rd++;
                got = !(skip && !t.w && t.a == 32'h8);
            end
            if (!got) @(negedge CLK);
        end
        if (!got) t = '1;
        chk(tag, 96'(t), 96'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, base;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_ready, rx_valid, rx_data, init_done, err_o}, 0);

        RST = 1'b0;
        push_exp(1'b1, 32'h0, 32'h36);
        push_exp(1'b1, 32'h4, 32'h3);
        push_exp(1'b0, 32'h8, 32'h0);
        check_txn("init_div", 0);
        check_txn("init_lcr", 0);
        check_txn("first_stat", 0);
        chk("init_done", init_done, 1);

        base = txr_cnt;
        tx_data = 8'hA5; tx_valid = 1'b1; stat_val = 32'h1;
        push_exp(1'b1, 32'hC, 32'hA5);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin @(negedge CLK); ok = tx_ready; end
        chk("tx_ready_seen", ok, 1);
        @(posedge CLK); #1 tx_valid = 1'b0;
        check_txn("txd_write", 1);
        chk("tx_ready_pulses", 96'(txr_cnt - base), 1);

        @(negedge CLK);
        tx_data = 8'h11; rxd_val = 32'h22; rx_ready = 1'b1; tx_valid = 1'b1; stat_val = 32'h3;
        push_exp(1'b0, 32'h10, 32'h22);
        push_exp(1'b1, 32'hC, 32'h11);
        push_exp(1'b0, 32'h10, 32'h22);
        push_exp(1'b1, 32'hC, 32'h11);
        check_txn("rr_rx1", 1);
        check_txn("rr_tx1", 1);
        check_txn("rr_rx2", 1);
        check_txn("rr_tx2", 1);
        tx_valid = 1'b0; stat_val = 32'h0;
        repeat (40) @(negedge CLK);

        rx_ready = 1'b0; rd = act_q.size(); rxd_val = 32'h5A; stat_val = 32'h2;
        push_exp(1'b0, 32'h10, 32'h5A);
        check_txn("rxd_read", 1);
        repeat (2) @(negedge CLK);
        chk("rx_hold", {rx_valid, rx_data}, {1'b1, 8'h5A});
        rd = act_q.size();
        repeat (60) @(negedge CLK);
        n = 0;
        for (int i = rd; i < act_q.size(); i++) if (act_q[i].a == 32'h10) n++;
        chk("no_rxd_while_full", 96'(n), 0);
        chk("rx_still_held", {rx_valid, rx_data}, {1'b1, 8'h5A});
        rxd_val = 32'h3C; rx_ready = 1'b1;
        @(posedge CLK); #1 rx_ready = 1'b0;
        push_exp(1'b0, 32'h10, 32'h3C);
        check_txn("rxd_reread", 1);
        repeat (2) @(negedge CLK);
        chk("rx_second", {rx_valid, rx_data}, {1'b1, 8'h3C});

        rx_ready = 1'b1; stat_val = 32'h0;
        repeat (5) @(negedge CLK);
        rx_ready = 1'b0; rd = act_q.size(); slverr_rx = 1'b1; rxd_val = 32'h77; stat_val = 32'h2;
        push_exp(1'b0, 32'h10, 32'h77);
        check_txn("rxd_slverr", 1);
        @(negedge CLK);
        chk("slverr_err_rxvalid", {err_o, rx_valid}, 2'b10);

        slverr_rx = 1'b0; stat_val = 32'h1; tx_data = 8'h99; tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge CLK); ok = tx_ready; end
        @(posedge CLK); #1 tx_valid = 1'b0; stall = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge CLK); ok = PSEL && PENABLE && PADDR == 32'hC; end
        chk("txd_access_seen", ok, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("rst_abort", {PSEL, PENABLE, init_done, err_o}, 0);
        stall = 1'b0; stat_val = 32'h0;
        @(negedge CLK);
        RST = 1'b0; rd = act_q.size();
        @(negedge CLK);
        chk("restart_setup", {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b0, 1'b1, 32'h0});
        push_exp(1'b1, 32'h0, 32'h36);
        push_exp(1'b1, 32'h4, 32'h3);
        check_txn("reinit_div", 0);
        check_txn("reinit_lcr", 0);

        stall = 1'b1;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin @(negedge CLK); ok = PSEL && !PENABLE; end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (!(PSEL && PENABLE)) break;
            n++;
        end
        chk("timeout_access_cycles", 96'(n), 16);
        chk("timeout_err", {PSEL, err_o}, 2'b01);
        stall = 1'b0; rd = act_q.size();
        push_exp(1'b0, 32'h8, 32'h0);
        check_txn("poll_resumes", 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
